// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator with early exit on the first differing digit.
// Signed operands are handled by flipping the sign bit at capture so a plain unsigned digit compare orders them.
module seq_magnitude_comparator #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int N     = WIDTH / DIGIT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDX_W-1:0] r_idx;
    logic             r_gt;
    logic             r_eq;
    logic             r_lt;

    logic             w_accept;
    logic [WIDTH-1:0] w_a_cap;
    logic [WIDTH-1:0] w_b_cap;
    logic [DIGIT-1:0] w_da;
    logic [DIGIT-1:0] w_db;
    logic             w_differ;
    logic             w_last;

    function automatic logic [DIGIT-1:0] digit_at(input logic [WIDTH-1:0] v,
                                                  input logic [IDX_W-1:0] idx);
        logic [WIDTH-1:0] shifted;
        shifted  = v >> (int'(idx) * DIGIT);
        digit_at = shifted[DIGIT-1:0];
    endfunction

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_a_cap  = signed_mode ? (a ^ MSB_MASK) : a;
    assign w_b_cap  = signed_mode ? (b ^ MSB_MASK) : b;
    assign w_da     = digit_at(r_a, r_idx);
    assign w_db     = digit_at(r_b, r_idx);
    assign w_differ = (w_da != w_db);
    assign w_last   = (r_idx == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = start ? S_COMPARE : S_IDLE;
            S_COMPARE: w_next = (w_differ || w_last) ? S_DONE : S_COMPARE;
            S_DONE:    w_next = start ? S_COMPARE : S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_COMPARE);
        done = (r_state == S_DONE);
        gt   = r_gt;
        eq   = r_eq;
        lt   = r_lt;
    end

    // Operand capture, digit walk and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_idx <= '0;
            r_gt  <= 1'b0;
            r_eq  <= 1'b0;
            r_lt  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= w_a_cap;
            r_b   <= w_b_cap;
            r_idx <= IDX_TOP;
        end else if (r_state == S_COMPARE) begin
            if (w_differ) begin
                r_gt <= (w_da > w_db);
                r_lt <= (w_da < w_db);
                r_eq <= 1'b0;
            end else if (w_last) begin
                r_gt <= 1'b0;
                r_lt <= 1'b0;
                r_eq <= 1'b1;
            end else begin
                r_idx <= r_idx - 1'b1;
            end
        end
    end

endmodule

// File: doc/seq_magnitude_comparator.md
# seq_magnitude_comparator

Parametrised, multi-cycle magnitude comparator that generalises the team's 2-bit combinational A>B block. It compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle, and exits early at the first differing digit. It reports greater, equal and less, in unsigned or two's-complement mode, through a start/done handshake. It sits in datapaths where wide comparisons must be spread over several cycles to meet timing.

## Interface
- WIDTH, default 8: operand width in bits; must be ≥ 2.
- DIGIT, default 1: bits compared per cycle; must divide WIDTH exactly.
- clk  input  1: clock; all state changes on the rising edge.
- rst_n  input  1: reset, asynchronous, active-low.
- start  input  1: request a comparison; sampled only while busy = 0.
- a  input  WIDTH: operand A; captured on the accepting edge.
- b  input  WIDTH: operand B; captured on the accepting edge.
- signed_mode  input  1: 1 means operands are two's complement, 0 means unsigned; captured with the operands.
- busy  output  1: comparison in progress.
- done  output  1: one-cycle pulse marking that the result outputs have just updated.
- gt  output  1: A > B for the last completed comparison.
- eq  output  1: A == B for the last completed comparison.
- lt  output  1: A < B for the last completed comparison.

## Operation
- N = WIDTH/DIGIT digits. Digit N-1 is the most significant.
- States:
  - IDLE: busy = 0. start = 1 captures a, b and signed_mode, loads the digit index with N-1, and moves to COMPARE.
  - COMPARE: busy = 1. Each cycle compares digit[idx] of the captured A against the captured B, as unsigned DIGIT-bit values.
    - Digits differ: register gt/lt from that digit, set eq = 0, go to DONE.
    - Digits equal and idx = 0: register eq = 1, gt = lt = 0, go to DONE.
    - Otherwise: decrement idx and stay in COMPARE.
  - DONE: done = 1 and busy = 0 for exactly one cycle, then IDLE. start in this cycle is accepted exactly as in IDLE, so back-to-back operations work.
- Signed mode: bit WIDTH-1 of both captured operands is inverted at capture (offset-binary). An unsigned digit compare then gives the correct signed order.
- After the first completion, exactly one of gt/eq/lt is 1. The outputs hold their value until the next completion and do not change while busy.
- start while busy = 1 is ignored. It is not queued, and the operand registers do not change.
- Input operands may change freely after the accepting edge.

## Timing
- Reset (asynchronous assert, any state): state goes to IDLE; busy, done, gt, eq and lt all go to 0; the operand registers and idx are cleared.
  - A comparison in flight is aborted. No done pulse follows.
  - Operation resumes on the first rising edge with rst_n = 1.
- Latency: start accepted at edge k gives busy = 1 from edge k.
  - The deciding digit is the n-th digit examined, 1 ≤ n ≤ N.
  - gt/eq/lt update and done rises at edge k+n. done falls at edge k+n+1.
  - busy falls at edge k+n.
- Best case is 1 cycle (MSB digit differs). Worst case is N cycles (equal operands, or difference only in digit 0).
- Maximum throughput is one comparison per n+1 cycles when start is held high.

## Test plan
- Reset: drive rst_n low mid-clock with start = 1 → busy = done = gt = eq = lt = 0 immediately; no activity until rst_n is released.
- Early exit (WIDTH=8, DIGIT=1, unsigned): a = 0xA5, b = 0x5A → gt = 1, eq = lt = 0, done 1 cycle after acceptance; swapping the operands → lt = 1.
- Full length: a = b = 0x3C → eq = 1 after 8 cycles. a = 0x01, b = 0x00 → gt = 1 after 8 cycles; a second start pulsed at cycle 3 is ignored, and the result and latency are unchanged.
- Signed mode: a = 0x80, b = 0x7F, signed_mode = 1 → lt = 1 in 1 cycle. The same operands with signed_mode = 0 → gt = 1. a = 0xFF, b = 0xFE signed → gt = 1 in 8 cycles.
- Handshake: start held high across operations → a new comparison is accepted in each DONE cycle; the done pulse is exactly one cycle wide; the outputs hold between completions.
- Reset mid-operation and DIGIT=4:
  - With WIDTH=8, DIGIT=4: a = 0x12, b = 0x13 → lt = 1, done 2 cycles after acceptance.
  - Asserting rst_n low on cycle 1 of a run → no done, all outputs 0; a following comparison runs to completion correctly.
